// File: rtl/timer_countdown.sv
// timer_countdown: MM:SS BCD countdown datapath for the digital timer.
// Loads sanitised presets, decrements once per prescaled second, flags done.
module timer_countdown #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       run,
  input  logic [3:0] set_min_tens,
  input  logic [3:0] set_min_ones,
  input  logic [3:0] set_sec_tens,
  input  logic [3:0] set_sec_ones,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       tick,
  output logic       done
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc;
  logic          roll;
  logic          zero;
  logic          one;
  logic [3:0]    ld_mt, ld_mo, ld_st, ld_so;
  logic [3:0]    dn_mt, dn_mo, dn_st, dn_so;
  logic          b1, b2, b3;

  // clamp presets to valid BCD; seconds tens limited to 5
  always_comb begin
    ld_mt = (set_min_tens > 4'd9) ? 4'd9 : set_min_tens;
    ld_mo = (set_min_ones > 4'd9) ? 4'd9 : set_min_ones;
    ld_st = (set_sec_tens > 4'd5) ? 4'd5 : set_sec_tens;
    ld_so = (set_sec_ones > 4'd9) ? 4'd9 : set_sec_ones;
  end

  // one-second BCD decrement with borrow chain
  always_comb begin
    b1    = (sec_ones == 4'd0);
    dn_so = b1 ? 4'd9 : sec_ones - 4'd1;
    b2    = b1 && (sec_tens == 4'd0);
    dn_st = b1 ? (b2 ? 4'd5 : sec_tens - 4'd1) : sec_tens;
    b3    = b2 && (min_ones == 4'd0);
    dn_mo = b2 ? (b3 ? 4'd9 : min_ones - 4'd1) : min_ones;
    dn_mt = b3 ? min_tens - 4'd1 : min_tens;
  end

  assign roll = (presc == LAST);
  assign zero = ({min_tens, min_ones, sec_tens, sec_ones} == 16'h0000);
  assign one  = ({min_tens, min_ones, sec_tens, sec_ones} == 16'h0001);

  // load beats run; run advances prescaler and counts down; else hold
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      min_tens <= 4'd0;
      min_ones <= 4'd0;
      sec_tens <= 4'd0;
      sec_ones <= 4'd0;
      presc    <= '0;
      tick     <= 1'b0;
      done     <= 1'b0;
    end else if (load) begin
      min_tens <= ld_mt;
      min_ones <= ld_mo;
      sec_tens <= ld_st;
      sec_ones <= ld_so;
      presc    <= '0;
      tick     <= 1'b0;
      done     <= 1'b0;
    end else if (run) begin
      tick  <= roll;
      presc <= roll ? '0 : presc + PW'(1);
      if (roll && !zero) begin
        min_tens <= dn_mt;
        min_ones <= dn_mo;
        sec_tens <= dn_st;
        sec_ones <= dn_so;
      end
      if (zero || (roll && one))
        done <= 1'b1;
    end else begin
      tick <= 1'b0;
    end
  end

endmodule
